// File: rtl/freq_synth_gen.sv
// Programmable square-wave generator: fractional phase accumulator producing 1..FMAX Hz from clk_50m.
// Optional macro FREQ_SYNTH_EDGE_CNT_EN adds a saturating rising-edge counter output (edge_cnt).
module freq_synth_gen #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned FMAX   = 9999,
  parameter int unsigned FW     = 14,
  parameter int unsigned ACC_W  = 27
) (
  input  logic          clk_50m,
  input  logic          rst_n,
  input  logic          load,
  input  logic [FW-1:0] freq_set,
  output logic          clk_out,
  output logic          busy,
  output logic          cfg_err,
  output logic [FW-1:0] freq_active
`ifdef FREQ_SYNTH_EDGE_CNT_EN
  ,
  output logic [FW+11:0] edge_cnt
`endif
);

  localparam logic [ACC_W-1:0] LP_CLK  = ACC_W'(CLK_HZ);
  localparam logic [FW-1:0]    LP_FMAX = FW'(FMAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [FW-1:0]    r_freq_active;
  logic [FW-1:0]    r_pending;
  logic             r_clk_out;
  logic             r_busy;
  logic             r_cfg_err;

  logic             w_load_ok;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;
  logic             w_fall;
  logic [FW-1:0]    w_next_freq;

  assign w_load_ok   = load && (freq_set <= LP_FMAX);
  assign w_sum       = r_acc + ACC_W'({r_freq_active, 1'b0});
  assign w_wrap      = (w_sum >= LP_CLK);
  assign w_fall      = w_wrap && r_clk_out;
  // A valid load landing on the switch cycle is the newest request, so it wins over pending.
  assign w_next_freq = w_load_ok ? freq_set : r_pending;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_freq_active <= '0;
      r_pending     <= '0;
      r_clk_out     <= 1'b0;
      r_busy        <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      if (load) r_cfg_err <= !w_load_ok;
      case (r_state)
        S_IDLE: begin
          r_acc     <= '0;
          r_clk_out <= 1'b0;
          if (w_load_ok && (freq_set != '0)) begin
            r_freq_active <= freq_set;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_wrap ? (w_sum - LP_CLK) : w_sum;
          if (w_wrap) r_clk_out <= !r_clk_out;
          if (w_load_ok) begin
            r_pending <= freq_set;
            r_busy    <= 1'b1;
            r_state   <= S_PEND;
          end
        end
        S_PEND: begin
          // Switching only on the falling toggle guarantees the high phase never gets cut short.
          if (w_fall) begin
            r_clk_out     <= 1'b0;
            r_acc         <= '0;
            r_freq_active <= w_next_freq;
            r_pending     <= '0;
            r_busy        <= 1'b0;
            r_state       <= (w_next_freq == '0) ? S_IDLE : S_RUN;
          end else begin
            r_acc <= w_wrap ? (w_sum - LP_CLK) : w_sum;
            if (w_wrap) r_clk_out <= !r_clk_out;
            if (w_load_ok) r_pending <= freq_set;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FREQ_SYNTH_EDGE_CNT_EN
  logic [FW+11:0] r_edge_cnt;
  logic           w_switch;
  logic           w_rise;

  assign w_switch = ((r_state == S_IDLE) && w_load_ok && (freq_set != '0)) ||
                    ((r_state == S_PEND) && w_fall);
  assign w_rise   = (r_state != S_IDLE) && w_wrap && !r_clk_out;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)                          r_edge_cnt <= '0;
    else if (w_switch)                   r_edge_cnt <= '0;
    else if (w_rise && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + 1'b1;
  end

  assign edge_cnt = r_edge_cnt;
`endif

  assign clk_out     = r_clk_out;
  assign busy        = r_busy;
  assign cfg_err     = r_cfg_err;
  assign freq_active = r_freq_active;

endmodule

// File: tb/tb_freq_synth_gen.sv
// Bench for freq_synth_gen with a scaled-down CLK_HZ so a "1 s" window is 20000 cycles.
// Expected toggle cycles come from the closed form base + ceil(k*CLK_HZ/(2f)) and are queued, then matched against observed toggles.
module tb_freq_synth_gen;
  localparam int CLK_HZ = 20000;
  localparam int FMAX   = 9999;
  localparam int FW     = 14;
  localparam int ACC_W  = 27;

  logic          clk_50m  = 1'b0;
  logic          rst_n    = 1'b0;
  logic          load     = 1'b0;
  logic [FW-1:0] freq_set = '0;
  logic          clk_out;
  logic          busy;
  logic          cfg_err;
  logic [FW-1:0] freq_active;
`ifdef FREQ_SYNTH_EDGE_CNT_EN
  logic [FW+11:0] edge_cnt;
`endif

  freq_synth_gen #(.CLK_HZ(CLK_HZ), .FMAX(FMAX), .FW(FW), .ACC_W(ACC_W)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .load       (load),
    .freq_set   (freq_set),
    .clk_out    (clk_out),
    .busy       (busy),
    .cfg_err    (cfg_err),
    .freq_active(freq_active)
`ifdef FREQ_SYNTH_EDGE_CNT_EN
    ,
    .edge_cnt   (edge_cnt)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Observed toggles (cycle index and new level), recorded shortly after each active edge.
  int   act_t[$];
  logic act_v[$];
  logic prev_clk = 1'b0;
  always @(posedge clk_50m) begin
    #1;
    if (clk_out !== prev_clk) begin
      act_t.push_back(cyc);
      act_v.push_back(clk_out);
      prev_clk = clk_out;
    end
  end

  int exp_t[$];
  int rd    = 0;
  int total = 0;
  int bad   = 0;
  int base  = 0;
  int knext = 1;

  function automatic int tog_at(int b, int f, int k);
    return b + int'((longint'(k) * CLK_HZ + 2 * f - 1) / (2 * f));
  endfunction

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk_50m);
  endtask

  task automatic load_f(int f);
    load     = 1'b1;
    freq_set = FW'(f);
    @(negedge clk_50m);
    load     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    rd = act_t.size();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_50m);
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b want=0", clk_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    total++; if (freq_active !== '0) begin bad++; $display("FAIL reset_freq_active got=%0d want=0", freq_active); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50m);
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL idle_clk_out got=%b want=0", clk_out); end
    rd = act_t.size();
  endtask

  task automatic test_f1000();
    int nr;
    load_f(1000);
    base = cyc;
    total++; if (freq_active !== FW'(1000)) begin bad++; $display("FAIL f1000_active got=%0d want=1000", freq_active); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL f1000_busy got=%b want=0", busy); end
    for (int k = 1; k <= 2000; k++) exp_t.push_back(tog_at(base, 1000, k));
    knext = 2001;
    wait_until(base + CLK_HZ + 2);
    nr = 0;
    for (int i = rd; i < act_t.size(); i++) if (act_v[i] === 1'b1 && act_t[i] <= base + CLK_HZ) nr++;
    total++; if (nr != 1000) begin bad++; $display("FAIL f1000_rises got=%0d want=1000", nr); end
`ifdef FREQ_SYNTH_EDGE_CNT_EN
    total++; if (edge_cnt !== 26'(1000)) begin bad++; $display("FAIL f1000_edge_cnt got=%0d want=1000", edge_cnt); end
`endif
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL f1000_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL f1000_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  task automatic test_cfg_err();
    int kf, sw, n;
    load_f(12000);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_set got=%b want=1", cfg_err); end
    total++; if (freq_active !== FW'(1000)) begin bad++; $display("FAIL cfg_err_active got=%0d want=1000", freq_active); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cfg_err_busy got=%b want=0", busy); end
    for (int k = knext; k < knext + 6; k++) exp_t.push_back(tog_at(base, 1000, k));
    wait_until(tog_at(base, 1000, knext + 5) + 2);
    knext += 6;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_hold got=%b want=1", cfg_err); end
    load_f(500);
    n = cyc;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_clear got=%b want=0", cfg_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend500_busy got=%b want=1", busy); end
    kf = knext;
    while (tog_at(base, 1000, kf) <= n || (kf % 2) != 0) kf++;
    for (int k = knext; k <= kf; k++) exp_t.push_back(tog_at(base, 1000, k));
    sw = tog_at(base, 1000, kf);
    wait_until(sw - 1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pend500_busy_hold got=%b want=1", busy); end
    @(negedge clk_50m);
    total++; if (freq_active !== FW'(500)) begin bad++; $display("FAIL sw500_active got=%0d want=500", freq_active); end
    base = sw;
    for (int k = 1; k <= 4; k++) exp_t.push_back(tog_at(base, 500, k));
    wait_until(tog_at(base, 500, 4) + 2);
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL cfg_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL cfg_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_f(1000);
    base = cyc;
    wait_until(base + 13);
    load_f(2000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    total++; if (freq_active !== FW'(1000)) begin bad++; $display("FAIL b2b_active_old got=%0d want=1000", freq_active); end
    wait_until(base + 16);
    load_f(4000);
    wait_until(base + 19);
    total++; if (busy !== 1'b1 || clk_out !== 1'b1) begin bad++; $display("FAIL b2b_high_phase got=busy%b/clk%b want=busy1/clk1", busy, clk_out); end
    @(negedge clk_50m);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_clear got=%b want=0", busy); end
    total++; if (freq_active !== FW'(4000)) begin bad++; $display("FAIL b2b_active_new got=%0d want=4000", freq_active); end
    exp_t.push_back(tog_at(base, 1000, 1));
    exp_t.push_back(tog_at(base, 1000, 2));
    base = base + 20;
    for (int k = 1; k <= 8; k++) exp_t.push_back(tog_at(base, 4000, k));
    knext = 9;
    wait_until(tog_at(base, 4000, 8) + 2);
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL b2b_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL b2b_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  task automatic test_stop();
    int kf, sw, n;
    load_f(0);
    n = cyc;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy got=%b want=1", busy); end
    total++; if (freq_active !== FW'(4000)) begin bad++; $display("FAIL stop_active_old got=%0d want=4000", freq_active); end
    kf = knext;
    while (tog_at(base, 4000, kf) <= n || (kf % 2) != 0) kf++;
    for (int k = knext; k <= kf; k++) exp_t.push_back(tog_at(base, 4000, k));
    sw = tog_at(base, 4000, kf);
    wait_until(sw + 30);
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL stop_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL stop_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
    total++; if (act_t.size() != rd) begin bad++; $display("FAIL stop_extra_edges got=%0d want=0", act_t.size() - rd); end
    total++; if (clk_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stop_idle got=clk%b/busy%b want=clk0/busy0", clk_out, busy); end
    total++; if (freq_active !== '0) begin bad++; $display("FAIL stop_active got=%0d want=0", freq_active); end
    rd = act_t.size();
  endtask

  task automatic test_f3();
    int nr;
    load_f(3);
    base = cyc;
    total++; if (freq_active !== FW'(3)) begin bad++; $display("FAIL f3_active got=%0d want=3", freq_active); end
    for (int k = 1; k <= 6; k++) exp_t.push_back(tog_at(base, 3, k));
    wait_until(base + CLK_HZ + 2);
    nr = 0;
    for (int i = rd; i < act_t.size(); i++) if (act_v[i] === 1'b1 && act_t[i] <= base + CLK_HZ) nr++;
    total++; if (nr != 3) begin bad++; $display("FAIL f3_rises got=%0d want=3", nr); end
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL f3_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL f3_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  task automatic test_fmax();
    int nr;
    do_reset();
    load_f(FMAX + 1);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL fmax1_cfg_err got=%b want=1", cfg_err); end
    total++; if (freq_active !== '0) begin bad++; $display("FAIL fmax1_active got=%0d want=0", freq_active); end
    repeat (20) @(negedge clk_50m);
    total++; if (act_t.size() != rd || clk_out !== 1'b0) begin bad++; $display("FAIL fmax1_output got=%0d edges want=0", act_t.size() - rd); end
    rd = act_t.size();
    load_f(FMAX);
    base = cyc;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL fmax_cfg_err got=%b want=0", cfg_err); end
    total++; if (freq_active !== FW'(FMAX)) begin bad++; $display("FAIL fmax_active got=%0d want=%0d", freq_active, FMAX); end
    for (int k = 1; k <= 2 * FMAX; k++) exp_t.push_back(tog_at(base, FMAX, k));
    wait_until(base + CLK_HZ + 2);
    nr = 0;
    for (int i = rd; i < act_t.size(); i++) if (act_v[i] === 1'b1 && act_t[i] <= base + CLK_HZ) nr++;
    total++; if (nr != FMAX) begin bad++; $display("FAIL fmax_rises got=%0d want=%0d", nr, FMAX); end
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL fmax_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL fmax_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  task automatic test_reset_high();
    int guard = 0;
    while (clk_out !== 1'b1 && guard < 20) begin @(negedge clk_50m); guard++; end
    total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL rsthi_no_high got=%b want=1", clk_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rsthi_clk_out got=%b want=0", clk_out); end
    total++; if (freq_active !== '0 || busy !== 1'b0 || cfg_err !== 1'b0) begin bad++; $display("FAIL rsthi_outputs got=%0d/%b/%b want=0/0/0", freq_active, busy, cfg_err); end
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    rd = act_t.size();
    load_f(1000);
    base = cyc;
    exp_t.push_back(tog_at(base, 1000, 1));
    exp_t.push_back(tog_at(base, 1000, 2));
    wait_until(base + 22);
    while (exp_t.size() > 0) begin
      int e = exp_t.pop_front();
      total++;
      if (rd >= act_t.size()) begin bad++; $display("FAIL rsthi_edge got=none want=%0d", e); end
      else begin
        if (act_t[rd] != e) begin bad++; $display("FAIL rsthi_edge got=%0d want=%0d", act_t[rd], e); end
        rd++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_f1000();
    test_cfg_err();
    test_back_to_back();
    test_stop();
    test_f3();
    test_fmax();
    test_reset_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_synth_gen.md
Name: freq_synth_gen

Overview:
- Programmable square-wave generator for the decimal frequency-measurement path.
- Produces clk_out at an integer frequency of 1..9999 Hz from clk_50m.
- Uses a fractional phase accumulator, so the average frequency over any 1 s window is exact to ±1 edge.
- Serves as the stimulus source driven into the frequency meter's clk_measure input; loads new settings glitch-free.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz (accumulator modulus)
FMAX, 9999, largest accepted frequency setting in Hz
FW, 14, width of frequency setting buses
ACC_W, 27, accumulator width; must hold 2*FMAX + CLK_HZ - 1

Ports:
clk_50m  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
load  input  1  single-cycle strobe; capture freq_set
freq_set  input  FW  requested frequency in Hz; 0 = stop
clk_out  output  1  generated square wave, registered
busy  output  1  new setting accepted, waiting for switch point
cfg_err  output  1  last load was out of range (freq_set > FMAX)
freq_active  output  FW  frequency currently being generated

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk_50m.
- All outputs and state are registered. Reset forces:
  - clk_out=0, busy=0, cfg_err=0, freq_active=0
  - acc=0, pending=0, state IDLE
- A reset mid-operation takes effect immediately, including in the high phase.
- States:
  - IDLE: clk_out held 0, acc held 0.
  - RUN: generating at freq_active.
  - PEND: generating at freq_active while a new value waits in pending.
- Range check, in any state, when load=1:
  - freq_set > FMAX: next cycle cfg_err=1. No other state changes.
  - freq_set <= FMAX: next cycle cfg_err=0.
- IDLE, valid load with f>0: next cycle freq_active=f, acc=0, state RUN. Valid load with f=0 stays in IDLE.
- RUN, every cycle:
  - sum = acc + 2*freq_active.
  - If sum >= CLK_HZ: acc <= sum - CLK_HZ and clk_out toggles. Otherwise acc <= sum.
  - First rising edge comes ceil(CLK_HZ/(2f)) cycles after entry to RUN.
  - Half-periods are floor or ceil of CLK_HZ/(2f) cycles; jitter is at most 1 clk_50m cycle.
- RUN, valid load: pending=f, busy=1, state PEND. Accumulation continues unchanged.
- PEND:
  - Accumulation continues at the old frequency.
  - A further valid load overwrites pending (last wins, no error). An invalid load sets cfg_err and leaves pending unchanged.
  - On the cycle where clk_out toggles 1->0:
    - freq_active <= pending, acc <= 0, busy <= 0.
    - State becomes RUN, or IDLE if pending=0.
  - Hence no runt pulse: a high phase always completes at the old rate.
- Simultaneous load and falling toggle in RUN: the toggle executes at the old frequency, the load enters PEND, and the switch occurs at the following falling edge.
- Arithmetic: sum uses ACC_W bits unsigned; no overflow for freq <= FMAX.

Optional Feature:
- Macro FREQ_SYNTH_EDGE_CNT_EN.
- When defined:
  - Adds output edge_cnt [FW+11:0], counting clk_out rising edges.
  - Cleared by reset and on every switch point (PEND->RUN/IDLE, IDLE->RUN).
  - Saturates at all-ones.
  - Used for self-check against the meter.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then load freq_set=1000 -> freq_active=1000 next cycle; first rise after 25000 cycles; high and low phases each exactly 25000 cycles; 1000 rising edges in 50_000_000 cycles.
- Load freq_set=3 -> half-periods of 8333333/8333334 cycles; exactly 3 rising edges in a 1 s window (±1 depending on window alignment).
- From RUN at 1000, load freq_set=12000 -> cfg_err=1 next cycle; freq_active stays 1000; waveform unaffected; a later valid load of 500 clears cfg_err.
- At 1000 Hz, load 2000 mid high phase, then load 4000 before the fall -> busy=1 until the falling edge; the high phase completes at 25000 cycles; then 4000 Hz (6250-cycle half-periods); 2000 is never generated.
- Load 0 while running -> clk_out finishes its current high phase, then stays 0; state IDLE; freq_active=0; busy=0.
- Assert rst_n=0 while clk_out=1 -> clk_out=0 immediately; all outputs at reset values. Loopback of clk_out into the frequency meter at 9999 Hz reports 9999.
